// File: rtl/polaris_prefetch.sv
// Instruction prefetch unit: runs ahead of the core, buffering up to DEPTH
// {word, pc} pairs, and handles redirects that flush the buffer mid-fetch.
module polaris_prefetch #(
  parameter int          AW        = 64,
  parameter int          DEPTH     = 4,
  parameter logic [63:0] RESET_VEC = 64'hFFFF_FFFF_FFFF_FF00
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  output logic [AW-1:0]          iadr_o,
  output logic [1:0]             isiz_o,
  input  logic                   iack_i,
  input  logic [31:0]            idat_i,
  output logic                   insn_valid_o,
  output logic [31:0]            insn_o,
  output logic [AW-1:0]          insn_pc_o,
  input  logic                   insn_pop_i,
  input  logic                   redirect_i,
  input  logic [AW-1:0]          redirect_adr_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int              PW     = $clog2(DEPTH);
  localparam int              CW     = PW + 1;
  localparam logic [CW-1:0]   FULL   = CW'(DEPTH);
  localparam logic [AW-1:0]   RST_PC = AW'(RESET_VEC) & ~AW'(3);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] fpc_q, fpc_d;
  logic [AW-1:0] areq_q, areq_d;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];

  logic [AW-1:0] target;
  logic [AW-1:0] areq_inc;
  logic [CW-1:0] count_after_push;
  logic          push;
  logic          pop;
  logic          unused_adr_bits;

  assign target           = {redirect_adr_i[AW-1:2], 2'b00};
  assign unused_adr_bits  = ^redirect_adr_i[1:0];
  assign areq_inc         = areq_q + AW'(4);
  assign push             = (state_q == REQ) && iack_i && !redirect_i;
  assign pop              = insn_pop_i && !redirect_i && (count_q != '0);
  assign count_after_push = count_q + CW'(1) - CW'(pop);

  always_comb begin
    count_d = count_q;
    if (redirect_i)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + CW'(1);
    else if (!push && pop)
      count_d = count_q - CW'(1);
  end

  // A request already on the bus cannot be withdrawn, so a redirect without
  // an ack parks in DISCARD until the stale response has been swallowed.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    areq_d  = areq_q;
    unique case (state_q)
      IDLE: begin
        if (redirect_i) begin
          fpc_d   = target;
          areq_d  = target;
          state_d = REQ;
        end else if (count_q < FULL) begin
          areq_d  = fpc_q;
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect_i) begin
          fpc_d = target;
          if (iack_i)
            areq_d = target;
          else
            state_d = DISCARD;
        end else if (iack_i) begin
          fpc_d = areq_inc;
          if (count_after_push < FULL)
            areq_d = areq_inc;
          else
            state_d = IDLE;
        end
      end
      DISCARD: begin
        if (redirect_i)
          fpc_d = target;
        if (iack_i) begin
          state_d = REQ;
          areq_d  = redirect_i ? target : fpc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      fpc_q    <= RST_PC;
      areq_q   <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      areq_q  <= areq_d;
      count_q <= count_d;
      if (redirect_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push)
          wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)
          rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Storage needs no reset: every read is gated by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr_q] <= idat_i;
      pc_mem[wr_ptr_q]   <= areq_q;
    end
  end

  assign iadr_o       = (state_q != IDLE) ? areq_q : '0;
  assign isiz_o       = (state_q != IDLE) ? 2'b10 : 2'b00;
  assign insn_valid_o = (count_q != '0);
  assign insn_o       = insn_valid_o ? data_mem[rd_ptr_q] : '0;
  assign insn_pc_o    = insn_valid_o ? pc_mem[rd_ptr_q] : '0;
  assign count_o      = count_q;

endmodule

// File: tb/tb_polaris_prefetch.sv
// Bench for polaris_prefetch: directed fetch/redirect scenarios, an AW=16
// wrap instance, and randomized traffic against a queue-based reference model.
module tb_polaris_prefetch;

  localparam int          DEPTH = 4;
  localparam logic [63:0] RV    = 64'hFFFF_FFFF_FFFF_FF00;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        reset_i, iack_i, insn_pop_i, redirect_i;
  logic [31:0] idat_i;
  logic [63:0] redirect_adr_i;
  logic [63:0] iadr_o, insn_pc_o;
  logic [1:0]  isiz_o;
  logic        insn_valid_o;
  logic [31:0] insn_o;
  logic [2:0]  count_o;

  polaris_prefetch #(.AW(64), .DEPTH(DEPTH), .RESET_VEC(RV)) u_dut (
    .clk_i(clk_i), .reset_i(reset_i), .iadr_o(iadr_o), .isiz_o(isiz_o),
    .iack_i(iack_i), .idat_i(idat_i), .insn_valid_o(insn_valid_o), .insn_o(insn_o),
    .insn_pc_o(insn_pc_o), .insn_pop_i(insn_pop_i), .redirect_i(redirect_i),
    .redirect_adr_i(redirect_adr_i), .count_o(count_o)
  );

  logic        reset16, iack16, pop16, redirect16;
  logic [31:0] idat16;
  logic [15:0] redirect_adr16, iadr16, insn_pc16;
  logic [1:0]  isiz16;
  logic        valid16;
  logic [31:0] insn16;
  logic [2:0]  count16;

  polaris_prefetch #(.AW(16), .DEPTH(4), .RESET_VEC(64'h0000_0000_0000_FFF8)) u_dut16 (
    .clk_i(clk_i), .reset_i(reset16), .iadr_o(iadr16), .isiz_o(isiz16),
    .iack_i(iack16), .idat_i(idat16), .insn_valid_o(valid16), .insn_o(insn16),
    .insn_pc_o(insn_pc16), .insn_pop_i(pop16), .redirect_i(redirect16),
    .redirect_adr_i(redirect_adr16), .count_o(count16)
  );

  int numTests  = 0;
  int numFailed = 0;

  typedef struct {
    logic [31:0] data;
    logic [63:0] pc;
  } entry_t;

  entry_t      mq[$];
  bit          m_busy, m_discard;
  logic [63:0] m_fpc, m_areq;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    numTests++;
    if (got !== exp) begin
      numFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_busy    = 1'b0;
    m_discard = 1'b0;
    m_fpc     = RV;
    m_areq    = '0;
  endtask

  // One clock of the prefetcher described as a buffer of fetched words plus
  // a bus-request pointer; the queue length is the occupancy.
  task automatic modelStep(input bit ack, input bit pop, input bit redir,
                           input logic [63:0] adr, input logic [31:0] dat);
    logic [63:0] tgt;
    int          size0;
    tgt   = {adr[63:2], 2'b00};
    size0 = mq.size();
    if (redir)
      mq.delete();
    else if (pop && size0 > 0)
      void'(mq.pop_front());
    if (!m_busy) begin
      if (redir) begin
        m_fpc  = tgt;
        m_areq = tgt;
        m_busy = 1'b1;
      end else if (size0 < DEPTH) begin
        m_areq = m_fpc;
        m_busy = 1'b1;
      end
    end else if (!m_discard) begin
      if (ack && !redir) begin
        mq.push_back('{dat, m_areq});
        m_fpc = m_areq + 64'd4;
        if (mq.size() < DEPTH)
          m_areq = m_fpc;
        else
          m_busy = 1'b0;
      end else if (redir) begin
        m_fpc = tgt;
        if (ack)
          m_areq = tgt;
        else
          m_discard = 1'b1;
      end
    end else begin
      if (redir)
        m_fpc = tgt;
      if (ack) begin
        m_discard = 1'b0;
        m_areq    = m_fpc;
      end
    end
  endtask

  task automatic compareModel();
    checkOutput("iadr",  iadr_o,           m_busy ? m_areq : 64'd0);
    checkOutput("isiz",  64'(isiz_o),      m_busy ? 64'd2 : 64'd0);
    checkOutput("valid", 64'(insn_valid_o), (mq.size() > 0) ? 64'd1 : 64'd0);
    checkOutput("insn",  64'(insn_o),      (mq.size() > 0) ? 64'(mq[0].data) : 64'd0);
    checkOutput("pc",    insn_pc_o,        (mq.size() > 0) ? mq[0].pc : 64'd0);
    checkOutput("count", 64'(count_o),     64'(mq.size()));
  endtask

  // Called at a falling edge: drive inputs, advance the model across the
  // next rising edge, then compare at the following falling edge.
  task automatic applyStimulus(input bit ack, input bit pop, input bit redir,
                               input logic [63:0] adr, input logic [31:0] dat);
    iack_i         = ack;
    insn_pop_i     = pop;
    redirect_i     = redir;
    redirect_adr_i = adr;
    idat_i         = dat;
    if (isiz_o == 2'b10 && ack && !redir)
      checkOutput("push_not_full", (int'(count_o) < DEPTH) ? 64'd1 : 64'd0, 64'd1);
    modelStep(ack, pop, redir, adr, dat);
    @(negedge clk_i);
    compareModel();
  endtask

  task automatic doReset();
    reset_i    = 1'b1;
    iack_i     = 1'b0;
    insn_pop_i = 1'b0;
    redirect_i = 1'b0;
    #1;
    checkOutput("rst_iadr",  iadr_o,            64'd0);
    checkOutput("rst_isiz",  64'(isiz_o),       64'd0);
    checkOutput("rst_valid", 64'(insn_valid_o), 64'd0);
    checkOutput("rst_insn",  64'(insn_o),       64'd0);
    checkOutput("rst_pc",    insn_pc_o,         64'd0);
    checkOutput("rst_count", 64'(count_o),      64'd0);
    modelReset();
    @(negedge clk_i);
    reset_i = 1'b0;
    compareModel();
  endtask

  initial begin
    reset_i = 1'b1; iack_i = 1'b0; insn_pop_i = 1'b0; redirect_i = 1'b0;
    idat_i = '0; redirect_adr_i = '0;
    reset16 = 1'b1; iack16 = 1'b1; pop16 = 1'b1; redirect16 = 1'b0;
    idat16 = 32'h1234_5678; redirect_adr16 = '0;
    repeat (2) @(negedge clk_i);

    // AW=16 instance: address arithmetic wraps through zero
    reset16 = 1'b0;
    @(negedge clk_i);
    checkOutput("w16_iadr", 64'(iadr16), 64'h0000_0000_0000_FFF8);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] exp16;
      @(negedge clk_i);
      exp16 = 16'hFFF8 + 16'(4 * i);
      checkOutput("w16_pc", 64'(insn_pc16), 64'(exp16));
    end
    reset16 = 1'b1;

    doReset();

    // Fill after reset with continuous ack and no pops
    applyStimulus(1, 0, 0, 64'd0, 32'hA000_0000);
    checkOutput("t1_iadr0", iadr_o, RV);
    checkOutput("t1_isiz0", 64'(isiz_o), 64'd2);
    for (int i = 1; i < 5; i++)
      applyStimulus(1, 0, 0, 64'd0, 32'hA000_0000 + 32'(i));
    checkOutput("t1_count", 64'(count_o), 64'd4);
    checkOutput("t1_isiz",  64'(isiz_o), 64'd0);
    checkOutput("t1_pc",    insn_pc_o, RV);
    checkOutput("t1_insn",  64'(insn_o), 64'hA000_0001);

    // One pop from full triggers exactly one refill at RV+16
    applyStimulus(0, 1, 0, 64'd0, 32'd0);
    applyStimulus(0, 0, 0, 64'd0, 32'd0);
    checkOutput("t2_iadr",  iadr_o, RV + 64'd16);
    applyStimulus(1, 0, 0, 64'd0, 32'hB000_0000);
    checkOutput("t2_count", 64'(count_o), 64'd4);
    applyStimulus(0, 0, 0, 64'd0, 32'd0);
    checkOutput("t2_isiz",  64'(isiz_o), 64'd0);

    // Redirect while a request is pending without ack
    applyStimulus(0, 1, 0, 64'd0, 32'd0);
    applyStimulus(0, 0, 0, 64'd0, 32'd0);
    checkOutput("t3_iadr_old", iadr_o, RV + 64'd20);
    applyStimulus(0, 0, 1, 64'h1000, 32'd0);
    checkOutput("t3_count",    64'(count_o), 64'd0);
    checkOutput("t3_iadr_hold", iadr_o, RV + 64'd20);
    applyStimulus(1, 0, 0, 64'd0, 32'hDEAD_BEEF);
    checkOutput("t3_dropped",  64'(insn_valid_o), 64'd0);
    checkOutput("t3_iadr_new", iadr_o, 64'h1000);
    applyStimulus(1, 0, 0, 64'd0, 32'h1111_1111);
    checkOutput("t3_pc",       insn_pc_o, 64'h1000);
    checkOutput("t3_insn",     64'(insn_o), 64'h1111_1111);

    // Redirect coincident with ack, misaligned target
    applyStimulus(1, 0, 1, 64'h2002, 32'h2222_2222);
    checkOutput("t4_iadr",  iadr_o, 64'h2000);
    checkOutput("t4_count", 64'(count_o), 64'd0);
    applyStimulus(1, 0, 0, 64'd0, 32'h3333_3333);
    checkOutput("t4_pc",    insn_pc_o, 64'h2000);
    checkOutput("t4_insn",  64'(insn_o), 64'h3333_3333);

    // Randomized traffic with alternating pop pressure and a mid-run reset
    for (int i = 0; i < 10000; i++) begin
      bit          ack, pop, redir;
      logic [63:0] adr;
      if (i == 5000)
        doReset();
      ack   = ($urandom_range(99) < 60);
      pop   = ($urandom_range(99) < (((i / 500) % 2 == 1) ? 80 : 15));
      redir = ($urandom_range(99) < 4);
      if ($urandom_range(3) == 0)
        adr = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      else
        adr = {$urandom, $urandom};
      applyStimulus(ack, pop, redir, adr, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", numTests, numFailed);
    $finish;
  end

endmodule
